// File: rtl/qupls4_mem_sched_np_if.sv
// qupls4_mem_sched_np_if: valid/ready issue bundle between the memory scheduler and the data-cache ports
interface qupls4_mem_sched_np_if #(
    parameter int NPORTS = 2,
    parameter int RRW = 3,
    parameter int CW = 1,
    parameter int RW = 5
);
    logic [NPORTS-1:0] port_v;
    logic [NPORTS-1:0] port_rdy;
    logic [NPORTS*RRW-1:0] port_row;
    logic [NPORTS*CW-1:0] port_col;
    logic [NPORTS*RW-1:0] port_rndx;
    modport master (output port_v, port_row, port_col, port_rndx, input port_rdy);
    modport slave (input port_v, port_row, port_col, port_rndx, output port_rdy);
endinterface

// File: rtl/qupls4_mem_sched_np.sv
// qupls4_mem_sched_np: oldest-first LSQ issue to NPORTS cache ports; define QUPLS4_MEM_SCHED_AGE_LIMIT_EN for starvation age limit
module qupls4_mem_sched_np #(
    parameter int LSQ_ROWS = 8,
    parameter int LSQ_COLS = 2,
    parameter int WINDOW = 8,
    parameter int NPORTS = 2,
    parameter int MAX_STORES = 1,
    parameter int ROB_ENTRIES = 32,
    parameter int STARVE_CYCLES = 64,
    localparam int N = LSQ_ROWS * LSQ_COLS,
    localparam int RW = $clog2(ROB_ENTRIES),
    localparam int RRW = $clog2(LSQ_ROWS),
    localparam int CW = LSQ_COLS > 1 ? $clog2(LSQ_COLS) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [RRW-1:0] lsq_head,
    input  logic [N-1:0] ent_v,
    input  logic [N-1:0] ent_ready,
    input  logic [N-1:0] ent_blocked,
    input  logic [N-1:0] ent_store,
    input  logic [N-1:0] ent_port0,
    input  logic [N*RW-1:0] ent_rndx,
    input  logic [N-1:0] ent_clr,
    input  logic [N-1:0] replay,
    input  logic [ROB_ENTRIES-1:0] stomp,
    qupls4_mem_sched_np_if.master dc,
    output logic [ROB_ENTRIES-1:0] memissue,
    output logic [N-1:0] inflight
);
    localparam int NW = WINDOW * LSQ_COLS;
    localparam int EW = $clog2(N);

    if (WINDOW > LSQ_ROWS || NPORTS < 1 || NPORTS > 4 || STARVE_CYCLES < 1) begin : g_bad_cfg
        $fatal(1, "qupls4_mem_sched_np: illegal WINDOW/NPORTS/STARVE_CYCLES configuration");
    end

    logic [NW-1:0][RRW-1:0] age_row;
    logic [NW-1:0][EW-1:0] age_ent;
    logic [N-1:0] stomped, cand, allow, issue;
    logic [NPORTS-1:0] free, taken, pick;
    logic [NPORTS-1:0][RRW-1:0] sel_row;
    logic [NPORTS-1:0][CW-1:0] sel_col;
    logic [NPORTS-1:0][RW-1:0] sel_rndx;
    logic [ROB_ENTRIES-1:0] mi_nxt;
    logic pend, ok;
    int nst;

    for (genvar a = 0; a < NW; a++) begin : g_age
        assign age_row[a] = lsq_head + RRW'(a / LSQ_COLS);
        assign age_ent[a] = EW'(age_row[a] * LSQ_COLS + a % LSQ_COLS);
    end

    for (genvar e = 0; e < N; e++) begin : g_stomp
        assign stomped[e] = stomp[ent_rndx[e*RW +: RW]];
    end

    assign cand = ent_v & ent_ready & ~ent_blocked & ~inflight & ~ent_clr & ~replay & ~stomped & allow;

`ifdef QUPLS4_MEM_SCHED_AGE_LIMIT_EN
    localparam int SW = $clog2(STARVE_CYCLES + 1);
    logic [SW-1:0] starve_cnt;
    logic [EW-1:0] old_e, old_q;
    logic old_found, starve;

    always_comb begin
        old_found = 1'b0;
        old_e = '0;
        for (int a = NW - 1; a >= 0; a--)
            if (ent_v[age_ent[a]] & !inflight[age_ent[a]]) begin
                old_found = 1'b1;
                old_e = age_ent[a];
            end
    end

    assign starve = old_found & (old_e == old_q) & (starve_cnt >= SW'(STARVE_CYCLES));
    assign allow = starve ? N'(1) << old_e : {N{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            old_q <= '0;
        end else begin
            old_q <= old_e;
            if (!old_found | (old_e != old_q) | issue[old_e] | ent_clr[old_e])
                starve_cnt <= '0;
            else if (starve_cnt < SW'(STARVE_CYCLES))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign allow = {N{1'b1}};
`endif

    // Walk the window oldest first; stores also wait behind any older unissued store.
    always_comb begin
        free = ~dc.port_v | dc.port_rdy;
        taken = '0;
        issue = '0;
        mi_nxt = '0;
        sel_row = '0;
        sel_col = '0;
        sel_rndx = '0;
        pend = 1'b0;
        nst = 0;
        ok = 1'b0;
        pick = '0;
        for (int a = 0; a < NW; a++) begin
            ok = cand[age_ent[a]] & !(ent_store[age_ent[a]] & (pend | nst >= MAX_STORES));
            pick = '0;
            for (int p = NPORTS - 1; p >= 0; p--)
                if (ok & free[p] & !taken[p] & ((p == 0) | !ent_port0[age_ent[a]]))
                    pick = NPORTS'(1) << p;
            for (int p = 0; p < NPORTS; p++)
                if (pick[p]) begin
                    taken[p] = 1'b1;
                    sel_row[p] = age_row[a];
                    sel_col[p] = CW'(a % LSQ_COLS);
                    sel_rndx[p] = ent_rndx[age_ent[a]*RW +: RW];
                    mi_nxt[ent_rndx[age_ent[a]*RW +: RW]] = 1'b1;
                end
            issue[age_ent[a]] = |pick;
            nst = nst + ((ent_store[age_ent[a]] & |pick) ? 1 : 0);
            pend = pend | (ent_v[age_ent[a]] & ent_store[age_ent[a]] & !inflight[age_ent[a]]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc.port_v <= '0;
            dc.port_row <= '0;
            dc.port_col <= '0;
            dc.port_rndx <= '0;
            memissue <= '0;
            inflight <= '0;
        end else begin
            memissue <= mi_nxt;
            inflight <= (inflight | issue) & ~(ent_clr | replay);
            for (int p = 0; p < NPORTS; p++) begin
                dc.port_v[p] <= taken[p] | (dc.port_v[p] & !dc.port_rdy[p] & !stomp[dc.port_rndx[p*RW +: RW]]);
                if (taken[p]) begin
                    dc.port_row[p*RRW +: RRW] <= sel_row[p];
                    dc.port_col[p*CW +: CW] <= sel_col[p];
                    dc.port_rndx[p*RW +: RW] <= sel_rndx[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_qupls4_mem_sched_np.sv
// tb_qupls4_mem_sched_np: directed scoreboard bench for qupls4_mem_sched_np (defaults; QUPLS4_MEM_SCHED_AGE_LIMIT_EN adds starvation steps)
module tb_qupls4_mem_sched_np;
`ifdef QUPLS4_MEM_SCHED_AGE_LIMIT_EN
    localparam int SC = 4;
`else
    localparam int SC = 64;
`endif
    logic clk = 1'b0;
    logic rst;
    logic [2:0] lsq_head;
    logic [15:0] ent_v, ent_ready, ent_blocked, ent_store, ent_port0, ent_clr, replay;
    logic [79:0] ent_rndx;
    logic [31:0] stomp, memissue;
    logic [15:0] inflight;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] v;
        logic [2:0] r0, r1;
        logic c0, c1;
        logic [4:0] x0, x1;
        logic [31:0] mi;
        logic [15:0] inf;
    } exp_t;
    exp_t sb[$];

    qupls4_mem_sched_np_if #(.NPORTS(2), .RRW(3), .CW(1), .RW(5)) dc ();

    qupls4_mem_sched_np #(.STARVE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .lsq_head(lsq_head), .ent_v(ent_v), .ent_ready(ent_ready),
        .ent_blocked(ent_blocked), .ent_store(ent_store), .ent_port0(ent_port0),
        .ent_rndx(ent_rndx), .ent_clr(ent_clr), .replay(replay), .stomp(stomp),
        .dc(dc), .memissue(memissue), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [1:0] v, input logic [2:0] r0, input logic c0,
                       input logic [4:0] x0, input logic [2:0] r1, input logic c1, input logic [4:0] x1,
                       input logic [31:0] mi, input logic [15:0] inf);
        exp_t e;
        e.v = v; e.r0 = r0; e.c0 = c0; e.x0 = x0; e.r1 = r1; e.c1 = c1; e.x1 = x1; e.mi = mi; e.inf = inf;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        chk({tag, ".port_v"}, 32'(dc.port_v), 32'(e.v));
        if (e.v[0]) begin
            chk({tag, ".row0"}, 32'(dc.port_row[2:0]), 32'(e.r0));
            chk({tag, ".col0"}, 32'(dc.port_col[0]), 32'(e.c0));
            chk({tag, ".rndx0"}, 32'(dc.port_rndx[4:0]), 32'(e.x0));
        end
        if (e.v[1]) begin
            chk({tag, ".row1"}, 32'(dc.port_row[5:3]), 32'(e.r1));
            chk({tag, ".col1"}, 32'(dc.port_col[1]), 32'(e.c1));
            chk({tag, ".rndx1"}, 32'(dc.port_rndx[9:5]), 32'(e.x1));
        end
        chk({tag, ".memissue"}, memissue, e.mi);
        chk({tag, ".inflight"}, 32'(inflight), 32'(e.inf));
    endtask

    task automatic set_ent(input int e, input logic st, input logic p0, input logic [4:0] x);
        ent_v[e] = 1'b1;
        ent_ready[e] = 1'b1;
        ent_store[e] = st;
        ent_port0[e] = p0;
        ent_rndx[e*5 +: 5] = x;
    endtask

    task automatic flush();
        ent_v = '0; ent_ready = '0; ent_blocked = '0; ent_store = '0; ent_port0 = '0;
        ent_rndx = '0; replay = '0; stomp = '0; dc.port_rdy = 2'b11; ent_clr = '1;
        step();
        ent_clr = '0;
    endtask

    initial begin
        rst = 1'b1;
        lsq_head = '0;
        ent_v = '0; ent_ready = '0; ent_blocked = '0; ent_store = '0; ent_port0 = '0;
        ent_rndx = '0; ent_clr = '0; replay = '0; stomp = '0; dc.port_rdy = 2'b11;
        cyc("reset", 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        chk("reset.row", 32'(dc.port_row), 32'h0);
        chk("reset.col", 32'(dc.port_col), 32'h0);
        chk("reset.rndx", 32'(dc.port_rndx), 32'h0);
        rst = 1'b0;
        set_ent(0, 0, 0, 5);
        set_ent(1, 0, 0, 6);
        cyc("two_loads", 2'b11, 0, 0, 5, 0, 1, 6, 32'h60, 16'h0003);
        cyc("two_loads_idle", 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0003);
        flush();
        lsq_head = 3'd7;
        set_ent(14, 0, 0, 10);
        set_ent(0, 0, 0, 11);
        cyc("wrap", 2'b11, 7, 0, 10, 0, 0, 11, 32'hC00, 16'h4001);
        flush();
        lsq_head = 3'd0;
        set_ent(2, 1, 0, 2);
        set_ent(3, 1, 0, 3);
        cyc("store_first", 2'b01, 1, 0, 2, 0, 0, 0, 32'h4, 16'h0004);
        cyc("store_second", 2'b01, 1, 1, 3, 0, 0, 0, 32'h8, 16'h000C);
        flush();
        ent_v[0] = 1'b1;
        ent_store[0] = 1'b1;
        set_ent(2, 1, 0, 2);
        set_ent(3, 1, 0, 3);
        set_ent(4, 0, 0, 4);
        cyc("store_blocked", 2'b01, 2, 0, 4, 0, 0, 0, 32'h10, 16'h0010);
        flush();
        set_ent(0, 0, 0, 5);
        cyc("hold_issue", 2'b01, 0, 0, 5, 0, 0, 0, 32'h20, 16'h0001);
        dc.port_rdy = 2'b10;
        set_ent(1, 0, 0, 6);
        set_ent(2, 0, 1, 7);
        cyc("hold1", 2'b11, 0, 0, 5, 0, 1, 6, 32'h40, 16'h0003);
        cyc("hold2", 2'b01, 0, 0, 5, 0, 0, 0, 32'h0, 16'h0003);
        cyc("hold3", 2'b01, 0, 0, 5, 0, 0, 0, 32'h0, 16'h0003);
        dc.port_rdy = 2'b11;
        cyc("port0_only", 2'b01, 1, 0, 7, 0, 0, 0, 32'h80, 16'h0007);
        flush();
        dc.port_rdy = 2'b10;
        set_ent(0, 0, 0, 5);
        cyc("stomp_load", 2'b01, 0, 0, 5, 0, 0, 0, 32'h20, 16'h0001);
        stomp[5] = 1'b1;
        cyc("stomp_drop", 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0001);
        stomp = '0;
        replay[0] = 1'b1;
        cyc("replay_clr", 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0000);
        replay = '0;
        dc.port_rdy = 2'b11;
        cyc("replay_issue", 2'b01, 0, 0, 5, 0, 0, 0, 32'h20, 16'h0001);
        cyc("replay_pulse", 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0001);
        flush();
`ifdef QUPLS4_MEM_SCHED_AGE_LIMIT_EN
        set_ent(0, 0, 0, 9);
        set_ent(1, 0, 0, 1);
        set_ent(2, 0, 0, 2);
        ent_blocked[0] = 1'b1;
        ent_ready[1] = 1'b0;
        ent_ready[2] = 1'b0;
        for (int i = 0; i < 6; i++)
            cyc("starve_wait", 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0000);
        ent_blocked[0] = 1'b0;
        ent_ready[1] = 1'b1;
        ent_ready[2] = 1'b1;
        cyc("starve_only_oldest", 2'b01, 0, 0, 9, 0, 0, 0, 32'h200, 16'h0001);
        cyc("starve_release", 2'b11, 0, 1, 1, 1, 0, 2, 32'h6, 16'h0007);
        flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/qupls4_mem_sched_np.md
Name: qupls4_mem_sched_np

Overview:
- Parametrised successor to the Qupls4 two-port memory scheduler.
- Each cycle it picks up to NPORTS ready LSQ entries, oldest first, across a configurable window.
- Per-port valid/ready handshakes with output holding registers; per-entry in-flight tracking with replay; configurable store limit; in-order stores.
- Sits between the LSQ/memready logic and the NPORTS data-cache ports.

Parameters:
- LSQ_ROWS, 8, LSQ rows (power of 2).
- LSQ_COLS, 2, entries per row.
- WINDOW, 8, rows scanned from lsq_head; must be ≤ LSQ_ROWS, else $fatal at elaboration.
- NPORTS, 2, data ports (1..4).
- MAX_STORES, 1, stores issued per cycle (1..NPORTS).
- ROB_ENTRIES, 32, ROB size; RW = $clog2(ROB_ENTRIES).
- STARVE_CYCLES, 64, age-limit threshold (optional feature only).

Ports (N = LSQ_ROWS*LSQ_COLS, entry index e = row*LSQ_COLS+col; RRW = $clog2(LSQ_ROWS), CW = max(1,$clog2(LSQ_COLS))):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lsq_head  in  RRW  oldest LSQ row.
- ent_v  in  N  entry allocated.
- ent_ready  in  N  operands and address valid (memready).
- ent_blocked  in  N  upstream hazard (overlap, fence, previous fc/memop).
- ent_store  in  N  entry is a store.
- ent_port0  in  N  entry may issue on port 0 only.
- ent_rndx  in  N*RW  ROB index per entry.
- ent_clr  in  N  entry deallocated; clears in-flight state.
- replay  in  N  re-arm entry for issue (cache miss or conflict).
- stomp  in  ROB_ENTRIES  ROB stomp mask.
- port_rdy  in  NPORTS  port accepts the presented op.
- port_v  out  NPORTS  op presented.
- port_row  out  NPORTS*RRW  LSQ row.
- port_col  out  NPORTS*CW  LSQ column.
- port_rndx  out  NPORTS*RW  ROB index.
- memissue  out  ROB_ENTRIES  one-cycle pulse, bit per ROB entry issued.
- inflight  out  N  entry issued and not yet cleared or replayed.

Behaviour:
- Reset: port_v=0, port_row/col/rndx=0, memissue=0, inflight=0, starve counter=0.
- Scan order:
  - rows (lsq_head+r) mod LSQ_ROWS for r=0..WINDOW-1, with row wrap-around;
  - within a row, col 0 then up to LSQ_COLS-1;
  - age rank a = r*LSQ_COLS+col.
- Candidate: ent_v & ent_ready & !ent_blocked & !inflight & !ent_clr & !replay & !stomp[ent_rndx].
- Store ordering:
  - A store is not a candidate if any older in-window entry is a valid store with inflight=0.
  - Loads may bypass unissued stores; hazards are covered by ent_blocked.
  - At most MAX_STORES stores are assigned per cycle.
- Port free: !port_v[p] | port_rdy[p].
- Assignment, in age order:
  - Each candidate goes to the lowest-numbered free, not-yet-assigned port.
  - ent_port0 candidates take port 0 only. If port 0 is taken or not free, the entry is skipped and younger entries continue.
  - Scanning stops when all free ports are assigned.
- Latency: assignment is combinational in cycle t; on edge t+1 the port registers load and port_v=1. In cycle t+1, inflight[e]=1 and memissue[rndx]=1, lasting one cycle.
- Hold: if port_v & !port_rdy, all fields stay stable and no new assignment goes to that port.
- Transfer: port_v & port_rdy. The port reloads or clears at the next edge.
- Stomp: if a held op's rndx is stomped, port_v drops at the next edge without transfer. Its inflight stays 1 until ent_clr.
- inflight update priority: rst > ent_clr > replay (clear to 0) > issue (set). Replay on an entry with inflight=0 has no effect.
- Empty (no candidates): ports not holding go port_v=0; memissue=0.
- Duplicate rndx across ports is impossible; an entry issues at most once per arming.

Optional Feature:
- Macro: QUPLS4_MEM_SCHED_AGE_LIMIT_EN.
- Defined:
  - A counter increments each cycle the oldest valid in-window entry (a minimal, ent_v=1, inflight=0) is not assigned.
  - The counter resets on that entry's issue, on ent_clr, or when the oldest entry changes.
  - At count ≥ STARVE_CYCLES, only that entry may be assigned; all other candidates are masked until it issues. The counter saturates.
- Undefined: no counter; pure oldest-first greedy assignment.

Test Plan:
- Reset, then entries 0,1 as ready loads, rndx 5,6, all port_rdy=1 → next cycle port0 = {row0,col0,rndx5}, port1 = {row0,col1,rndx6}; memissue bits 5,6 for one cycle; inflight=0b11.
- lsq_head=7, entries e14 (row7) and e0 (row0, wrap) ready → e14 on port0, e0 on port1.
- Two ready stores e2, e3 with MAX_STORES=1 → only e2 issues; e3 issues the following cycle. An older unissued store e0 blocks both stores, while a ready load e4 still issues.
- port_rdy[0]=0 for 3 cycles holding rndx 5 → port0 fields stable for 3 cycles; new ops use port1 only; ent_port0 entry waits for port 0.
- stomp[5] while port0 holds rndx5 → port_v[0]=0 next cycle. replay[e0] → e0 reissues one cycle later with memissue[5] pulsed again.
- Macro defined, STARVE_CYCLES=4, oldest e0 blocked for 4 cycles then unblocked alongside ready e1, e2 → only e0 issues that cycle.
